// File: rtl/prod_accum_pkg.sv
// Shared types and saturation helpers for the signed product accumulator.
package prod_accum_pkg;

   typedef enum logic [0:0] {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   // Working width for the helpers; every caller width must stay well below this.
   localparam int unsigned WIDE_W = 64;

   typedef logic signed [WIDE_W-1:0] wide_t;

   typedef struct packed {
      wide_t sum;
      logic  sat;
   } sat_sum_t;

   // Largest value representable in a w-bit two's complement word.
   function automatic wide_t max_s(input int unsigned w);
      return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
   endfunction

   // Smallest value representable in a w-bit two's complement word.
   function automatic wide_t min_s(input int unsigned w);
      return -(wide_t'(1) <<< (w - 1));
   endfunction

   // Add two sign-extended operands and clamp to the w-bit signed range.
   function automatic sat_sum_t sat_add(input wide_t a, input wide_t b, input int unsigned w);
      wide_t    s;
      sat_sum_t r;
      s     = a + b;
      r.sum = s;
      r.sat = 1'b0;
      if (s > max_s(w)) begin
         r.sum = max_s(w);
         r.sat = 1'b1;
      end else if (s < min_s(w)) begin
         r.sum = min_s(w);
         r.sat = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/prod_accum_if.sv
// Product input stream and frame result stream of the accumulator.
interface prod_accum_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 16,
   parameter int LEN_W = 8
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [IN_W-1:0]  in_data;
   logic                    in_last;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [OUT_W-1:0] out_data;
   logic                    out_sat;
   logic [LEN_W-1:0]        out_count;

   // Upstream product source and downstream result consumer.
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_sat, out_count
   );

   // The accumulator itself.
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_sat, out_count
   );
endinterface

// File: rtl/prod_accum_sat_clip.sv
// Combinational signed narrowing with saturation and a clip indicator.
module sat_clip
   import prod_accum_pkg::*;
#(
   parameter int IN_W  = 24,
   parameter int OUT_W = 16
) (
   input  logic signed [IN_W-1:0]  i_val,
   output logic signed [OUT_W-1:0] o_val,
   output logic                    o_clip
);

   wide_t w_val;

   assign w_val = wide_t'(i_val);

   // Clamp to the narrow range, otherwise pass the low bits through.
   always_comb begin
      o_val  = OUT_W'(w_val);
      o_clip = 1'b0;
      if (w_val > max_s(OUT_W)) begin
         o_val  = OUT_W'(max_s(OUT_W));
         o_clip = 1'b1;
      end else if (w_val < min_s(OUT_W)) begin
         o_val  = OUT_W'(min_s(OUT_W));
         o_clip = 1'b1;
      end
   end

endmodule

// File: rtl/prod_accum.sv
// Signed product accumulator: sums each frame of products and emits one
// scaled, saturated result per frame.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_ACC   | accepting products, summing into r_acc
//   S_HOLD  | frame result presented, waiting for out_ready; input stalled
module prod_accum
   import prod_accum_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int ACC_W = 24,
   parameter int OUT_W = 16,
   parameter int SHIFT = 0,
   parameter int LEN_W = 8
) (
   input logic         clk,
   input logic         rst,
   prod_accum_if.slave io_bus
);

   localparam logic [0:0]       S_ACC   = ST_ACC;
   localparam logic [0:0]       S_HOLD  = ST_HOLD;
   localparam logic [LEN_W-1:0] CNT_MAX = '1;

   logic [0:0]              r_state;
   logic signed [ACC_W-1:0] r_acc;
   logic [LEN_W-1:0]        r_count;
   logic                    r_sat;
   logic signed [OUT_W-1:0] r_out_data;
   logic                    r_out_sat;
   logic [LEN_W-1:0]        r_out_count;

   logic                    w_fire;
   logic                    w_final;
   sat_sum_t                w_add;
   logic signed [ACC_W-1:0] w_acc_next;
   logic signed [ACC_W-1:0] w_acc_shift;
   logic [LEN_W-1:0]        w_count_next;
   logic signed [OUT_W-1:0] w_clip_val;
   logic                    w_clip;

   assign w_fire       = io_bus.in_valid && (r_state == S_ACC);
   assign w_final      = w_fire && io_bus.in_last;
   assign w_add        = sat_add(wide_t'(r_acc), wide_t'(io_bus.in_data), ACC_W);
   assign w_acc_next   = ACC_W'(w_add.sum);
   assign w_count_next = (r_count == CNT_MAX) ? r_count : r_count + 1'b1;

   // The result is taken from the sum that already includes the last sample.
   assign w_acc_shift  = w_acc_next >>> SHIFT;

   sat_clip #(
      .IN_W (ACC_W),
      .OUT_W(OUT_W)
   ) u_clip (
      .i_val (w_acc_shift),
      .o_val (w_clip_val),
      .o_clip(w_clip)
   );

   // Frame FSM with the running sum, sample count and sticky saturation flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_ACC;
         r_acc   <= '0;
         r_count <= '0;
         r_sat   <= 1'b0;
      end else if (r_state == S_ACC) begin
         if (w_fire) begin
            r_acc   <= w_acc_next;
            r_count <= w_count_next;
            r_sat   <= r_sat | w_add.sat;
            if (io_bus.in_last) begin
               r_state <= S_HOLD;
            end
         end
      end else begin
         if (io_bus.out_ready) begin
            r_state <= S_ACC;
            r_acc   <= '0;
            r_count <= '0;
            r_sat   <= 1'b0;
         end
      end
   end

   // Result registers load once per frame and keep their value afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_data  <= '0;
         r_out_sat   <= 1'b0;
         r_out_count <= '0;
      end else if (w_final) begin
         r_out_data  <= w_clip_val;
         r_out_sat   <= r_sat | w_add.sat | w_clip;
         r_out_count <= w_count_next;
      end
   end

   assign io_bus.in_ready  = (r_state == S_ACC);
   assign io_bus.out_valid = (r_state == S_HOLD);
   assign io_bus.out_data  = r_out_data;
   assign io_bus.out_sat   = r_out_sat;
   assign io_bus.out_count = r_out_count;

endmodule
